tim_counter: RTL and testbench

TIM_COUNTER -- requirements
Module: tim_counter

---
 rtl/tim_pkg.sv | 40 ++++
 rtl/tim_edge_detect.sv | 20 ++
 rtl/tim_counter.sv | 150 +++++++++++++++
 tb/tb_tim_counter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tim_pkg.sv
// Shared types and constants for the general-purpose timer/counter block.
// Capture support is compiled in only when TIM_CAPTURE_EN is defined.
package tim_pkg;

  localparam int         TIM_W      = 16;
  localparam logic [2:0] PRE_BYPASS = 3'b000;

  typedef logic [TIM_W-1:0] tim_cnt_t;

  typedef enum logic {
    MODE_PERIODIC = 1'b0,
    MODE_ONESHOT  = 1'b1
  } tim_mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } tim_state_e;

  // Control command decoded from the start/stop pulses; stop dominates start.
  typedef enum logic [1:0] {
    CMD_NONE  = 2'd0,
    CMD_START = 2'd1,
    CMD_STOP  = 2'd2,
    CMD_CLEAR = 2'd3
  } tim_cmd_e;

  function automatic tim_cmd_e decode_cmd(input logic start_p, input logic stop_p);
    if (stop_p && start_p) return CMD_CLEAR;
    if (stop_p)            return CMD_STOP;
    if (start_p)           return CMD_START;
    return CMD_NONE;
  endfunction

  // Sticky status bit: a set on the same edge as a clear wins.
  function automatic logic sticky_next(input logic set, input logic clr, input logic cur);
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/tim_edge_detect.sv
// One-flop delay of a synchronous input with a combinational rising-edge output.
// Used for the prescaled tick and for the capture trigger.
module tim_edge_detect (
  input  logic HCLK,
  input  logic n_RST,
  input  logic d,
  output logic rise
);

  logic d_q;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge HCLK or negedge n_RST) begin
    if (!n_RST) d_q <= 1'b0;
    else        d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/tim_counter.sv
// Timer/counter with compare match, one-shot/periodic modes and sticky status flags.
// Optional input capture on cap_in is enabled by defining TIM_CAPTURE_EN.
module tim_counter
  import tim_pkg::*;
(
  input  logic             HCLK,
  input  logic             n_RST,
  input  logic             tim_clk,
  input  logic [2:0]       PRE,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic [TIM_W-1:0] cmp,
  input  logic             irq_clr,
  input  logic             cap_in,
  output logic [TIM_W-1:0] count,
  output logic             running,
  output logic             match_flag,
  output logic             cap_flag,
  output logic [TIM_W-1:0] cap_val,
  output logic             irq
);

  tim_state_e state_q, state_d;
  tim_cmd_e   cmd;
  tim_cnt_t   count_d;
  logic       tim_rise;
  logic       tick;
  logic       count_en;
  logic       hit;
  logic       match_set;

  // ---------------------------------------------------------------------------
  // Tick generation: every cycle when undivided, else one per tim_clk rise
  // ---------------------------------------------------------------------------
  tim_edge_detect u_tick_edge (
    .HCLK  (HCLK),
    .n_RST (n_RST),
    .d     (tim_clk),
    .rise  (tim_rise)
  );

  assign tick = (PRE == PRE_BYPASS) ? 1'b1 : tim_rise;
  assign cmd  = decode_cmd(start, stop);
  assign hit  = count_en && (count == cmp);

  // ---------------------------------------------------------------------------
  // Run-control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge HCLK or negedge n_RST) begin
    if (!n_RST) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (cmd)
      CMD_STOP,
      CMD_CLEAR: state_d = ST_IDLE;
      CMD_START: state_d = ST_RUN;
      default: begin
        if (hit && (tim_mode_e'(mode) == MODE_ONESHOT)) state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    running  = (state_q == ST_RUN);
    count_en = running && tick;
  end

  // ---------------------------------------------------------------------------
  // Counter datapath; a restart never reports a match on its own edge
  // ---------------------------------------------------------------------------
  always_comb begin
    count_d   = count;
    match_set = 1'b0;
    case (cmd)
      CMD_START,
      CMD_CLEAR: count_d = '0;
      CMD_STOP:  count_d = count;
      default: begin
        if (hit) begin
          count_d   = '0;
          match_set = 1'b1;
        end else if (count_en) begin
          count_d = count + tim_cnt_t'(1);
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge n_RST) begin
    if (!n_RST) begin
      count      <= '0;
      match_flag <= 1'b0;
      irq        <= 1'b0;
    end else begin
      count      <= count_d;
      match_flag <= sticky_next(match_set, irq_clr, match_flag);
      irq        <= match_flag | cap_flag;
    end
  end

  // ---------------------------------------------------------------------------
  // Input capture
  // ---------------------------------------------------------------------------
`ifdef TIM_CAPTURE_EN
  logic cap_s1;
  logic cap_s2;
  logic cap_rise;

  // Two-flop synchronizer for the asynchronous capture pin.
  always_ff @(posedge HCLK or negedge n_RST) begin
    if (!n_RST) begin
      cap_s1 <= 1'b0;
      cap_s2 <= 1'b0;
    end else begin
      cap_s1 <= cap_in;
      cap_s2 <= cap_s1;
    end
  end

  tim_edge_detect u_cap_edge (
    .HCLK  (HCLK),
    .n_RST (n_RST),
    .d     (cap_s2),
    .rise  (cap_rise)
  );

  // Capture is independent of running; it latches the pre-edge count.
  always_ff @(posedge HCLK or negedge n_RST) begin
    if (!n_RST) begin
      cap_val  <= '0;
      cap_flag <= 1'b0;
    end else begin
      if (cap_rise) cap_val <= count;
      cap_flag <= sticky_next(cap_rise, irq_clr, cap_flag);
    end
  end
`else
  logic unused_cap_in;

  assign unused_cap_in = cap_in;
  assign cap_val       = '0;
  assign cap_flag      = 1'b0;
`endif

endmodule

// File: tb/tb_tim_counter.sv
// Self-checking bench for tim_counter: directed vector table, corner-case sequences
// and randomized stimulus compared each cycle against a behavioural model.
module tb_tim_counter;

  logic        HCLK    = 1'b0;
  logic        n_RST   = 1'b0;
  logic        tim_clk = 1'b0;
  logic [2:0]  PRE     = 3'd0;
  logic        start   = 1'b0;
  logic        stop    = 1'b0;
  logic        mode    = 1'b0;
  logic [15:0] cmp     = 16'd0;
  logic        irq_clr = 1'b0;
  logic        cap_in  = 1'b0;
  logic [15:0] count;
  logic        running;
  logic        match_flag;
  logic        cap_flag;
  logic [15:0] cap_val;
  logic        irq;

  tim_counter dut (
    .HCLK       (HCLK),
    .n_RST      (n_RST),
    .tim_clk    (tim_clk),
    .PRE        (PRE),
    .start      (start),
    .stop       (stop),
    .mode       (mode),
    .cmp        (cmp),
    .irq_clr    (irq_clr),
    .cap_in     (cap_in),
    .count      (count),
    .running    (running),
    .match_flag (match_flag),
    .cap_flag   (cap_flag),
    .cap_val    (cap_val),
    .irq        (irq)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural reference model, written from the block's rules
  // ---------------------------------------------------------------------------
  logic [15:0] m_count, m_capval;
  bit          m_running, m_match, m_cap, m_irq;
  bit          m_prev_clk;
  bit          smp [1:3];   // cap_in samples taken 1, 2 and 3 edges ago
  logic [7:0]  div_cnt = 8'd0;

  task automatic model_reset();
    m_count = 16'd0; m_capval = 16'd0;
    m_running = 0; m_match = 0; m_cap = 0; m_irq = 0; m_prev_clk = 0;
    for (int i = 1; i <= 3; i++) smp[i] = 0;
  endtask

  task automatic model_step();
    bit          tick, hit_evt, cap_evt;
    logic [15:0] old_count;
    if (!n_RST) begin
      model_reset();
      return;
    end
    tick       = (PRE == 3'd0) ? 1'b1 : (tim_clk && !m_prev_clk);
    m_prev_clk = tim_clk;
    old_count  = m_count;
    hit_evt    = 0;
    if (stop) begin
      m_running = 0;
      if (start) m_count = 16'd0;
    end else if (start) begin
      m_count   = 16'd0;
      m_running = 1;
    end else if (m_running && tick) begin
      if (m_count == cmp) begin
        m_count = 16'd0;
        hit_evt = 1;
        if (mode) m_running = 0;
      end else begin
        m_count = m_count + 16'd1;
      end
    end
    cap_evt = 0;
`ifdef TIM_CAPTURE_EN
    cap_evt = smp[2] && !smp[3];
    smp[3]  = smp[2];
    smp[2]  = smp[1];
    smp[1]  = cap_in;
`endif
    m_irq = m_match || m_cap;
    if (hit_evt) m_match = 1;
    else if (irq_clr) m_match = 0;
    if (cap_evt) begin
      m_cap    = 1;
      m_capval = old_count;
    end else if (irq_clr) begin
      m_cap = 0;
    end
  endtask

  task automatic check_model();
    check("model_count",   count,      m_count);
    check("model_running", running,    m_running);
    check("model_match",   match_flag, m_match);
    check("model_capflag", cap_flag,   m_cap);
    check("model_capval",  cap_val,    m_capval);
    check("model_irq",     irq,        m_irq);
  endtask

  // One HCLK cycle: model follows the edge, outputs compared on the falling edge,
  // then the stand-in clock divider advances.
  task automatic cycle();
    int p;
    @(posedge HCLK);
    model_step();
    @(negedge HCLK);
    check_model();
    div_cnt++;
    p       = int'(PRE);
    tim_clk = (p == 0) ? 1'b0 : div_cnt[p-1];
  endtask

  task automatic pulse_cycle();
    cycle();
    start = 0; stop = 0; irq_clr = 0; cap_in = 0;
  endtask

  typedef struct {
    bit          st, sp, md, clr;
    logic [15:0] c;
    logic [15:0] e_count;
    bit          e_run, e_match, e_irq;
  } vec_t;

  vec_t tbl [22];

  initial begin
    int c1, c2, n;
    bit found;

    tbl[0]  = '{1, 0, 0, 0, 16'd3, 16'd0, 1, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 16'd3, 16'd1, 1, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 16'd3, 16'd2, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 16'd3, 16'd3, 1, 0, 0};
    tbl[4]  = '{0, 0, 0, 0, 16'd3, 16'd0, 1, 1, 0};
    tbl[5]  = '{0, 0, 0, 0, 16'd3, 16'd1, 1, 1, 1};
    tbl[6]  = '{0, 0, 0, 1, 16'd3, 16'd2, 1, 0, 1};
    tbl[7]  = '{0, 0, 0, 0, 16'd3, 16'd3, 1, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 16'd3, 16'd3, 0, 0, 0};
    tbl[9]  = '{0, 0, 0, 0, 16'd3, 16'd3, 0, 0, 0};
    tbl[10] = '{1, 1, 0, 0, 16'd3, 16'd0, 0, 0, 0};
    tbl[11] = '{1, 0, 0, 0, 16'd3, 16'd0, 1, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 16'd0, 16'd0, 1, 1, 0};
    tbl[13] = '{0, 0, 0, 0, 16'd0, 16'd0, 1, 1, 1};
    tbl[14] = '{1, 0, 0, 1, 16'd0, 16'd0, 1, 0, 1};
    tbl[15] = '{0, 0, 0, 0, 16'd5, 16'd1, 1, 0, 0};
    tbl[16] = '{0, 0, 0, 0, 16'd2, 16'd2, 1, 0, 0};
    tbl[17] = '{0, 0, 0, 1, 16'd2, 16'd0, 1, 1, 0};
    tbl[18] = '{0, 0, 0, 1, 16'd2, 16'd1, 1, 0, 1};
    tbl[19] = '{0, 0, 0, 0, 16'd2, 16'd2, 1, 0, 0};
    tbl[20] = '{0, 0, 1, 0, 16'd2, 16'd0, 0, 1, 0};
    tbl[21] = '{0, 0, 1, 0, 16'd2, 16'd0, 0, 1, 1};

    // Reset state
    model_reset();
    @(negedge HCLK);
    check("rst_count", count, 16'd0);
    check("rst_running", running, 1'b0);
    check("rst_match", match_flag, 1'b0);
    check("rst_capflag", cap_flag, 1'b0);
    check("rst_capval", cap_val, 16'd0);
    check("rst_irq", irq, 1'b0);
    cycle();
    n_RST = 1;
    cycle();

    // Directed vector table, PRE=0
    for (int i = 0; i < 22; i++) begin
      start = tbl[i].st; stop = tbl[i].sp; mode = tbl[i].md;
      irq_clr = tbl[i].clr; cmp = tbl[i].c;
      cycle();
      check($sformatf("vec%0d_count", i), count, tbl[i].e_count);
      check($sformatf("vec%0d_running", i), running, tbl[i].e_run);
      check($sformatf("vec%0d_match", i), match_flag, tbl[i].e_match);
      check($sformatf("vec%0d_irq", i), irq, tbl[i].e_irq);
    end
    start = 0; stop = 0; mode = 0; irq_clr = 1;
    pulse_cycle();

    // Divide-by-4 one-shot with cmp=1
    PRE = 3'd2; cmp = 16'd1; mode = 1; start = 1;
    pulse_cycle();
    check("div4_start_count", count, 16'd0);
    check("div4_start_running", running, 1'b1);
    found = 0; c1 = 0;
    for (int k = 0; k < 16 && !found; k++) begin
      cycle();
      if (count == 16'd1) begin found = 1; c1 = k; end
    end
    check("div4_reach1_in_budget", found, 1'b1);
    found = 0; c2 = 0;
    for (int k = 0; k < 16 && !found; k++) begin
      cycle();
      if (!running) begin found = 1; c2 = c1 + 1 + k; end
    end
    check("div4_oneshot_end_in_budget", found, 1'b1);
    check("div4_tick_spacing", c2 - c1, 4);
    check("div4_end_count", count, 16'd0);
    check("div4_end_match", match_flag, 1'b1);
    for (int k = 0; k < 8; k++) cycle();
    check("div4_hold_count", count, 16'd0);
    check("div4_hold_running", running, 1'b0);

    // Start+stop together at count 5, then resume from 0
    PRE = 3'd0; mode = 0; cmp = 16'd100; irq_clr = 1; start = 1;
    pulse_cycle();
    for (int k = 0; k < 5; k++) cycle();
    check("ss_count5", count, 16'd5);
    start = 1; stop = 1;
    pulse_cycle();
    check("ss_count_cleared", count, 16'd0);
    check("ss_running_cleared", running, 1'b0);
    cycle();
    check("ss_idle_count", count, 16'd0);
    start = 1;
    pulse_cycle();
    check("ss_restart_running", running, 1'b1);
    cycle();
    check("ss_resume_count", count, 16'd1);

    // Capture while counting through 0x0010
    cmp = 16'hFFFF; start = 1;
    pulse_cycle();
    for (int k = 0; k < 16; k++) cycle();
    check("cap_pre_count", count, 16'h0010);
    cap_in = 1;
    pulse_cycle();
    cycle();
    cycle();
`ifdef TIM_CAPTURE_EN
    check("cap_flag_set", cap_flag, 1'b1);
    check("cap_val_window", (cap_val == 16'h0012) || (cap_val == 16'h0013), 1'b1);
`else
    check("cap_flag_off", cap_flag, 1'b0);
    check("cap_val_off", cap_val, 16'd0);
`endif
    irq_clr = 1;
    pulse_cycle();
    cycle();
    check("cap_cleared", cap_flag, 1'b0);
    check("cap_irq_cleared", irq, 1'b0);

    // Asynchronous reset at count 7, idle after release
    cmp = 16'd100; start = 1;
    pulse_cycle();
    for (int k = 0; k < 7; k++) cycle();
    check("arst_pre_count", count, 16'd7);
    #2 n_RST = 0;
    #1;
    check("arst_count", count, 16'd0);
    check("arst_running", running, 1'b0);
    check("arst_match", match_flag, 1'b0);
    check("arst_capflag", cap_flag, 1'b0);
    check("arst_capval", cap_val, 16'd0);
    check("arst_irq", irq, 1'b0);
    model_reset();
    cycle();
    n_RST = 1;
    for (int k = 0; k < 5; k++) cycle();
    check("arst_idle_count", count, 16'd0);
    check("arst_idle_running", running, 1'b0);

    // Randomized traffic against the model
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      start   = ($urandom_range(0, 99) < 4);
      stop    = ($urandom_range(0, 99) < 3);
      irq_clr = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 10) cap_in = ~cap_in;
      if ($urandom_range(0, 99) < 5)  mode = $urandom_range(0, 1);
      if ($urandom_range(0, 99) < 3)  cmp = 16'($urandom_range(0, 40));
      if ($urandom_range(0, 99) < 2)  PRE = 3'($urandom_range(0, 3));
      cycle();
      if (match_flag) n++;
    end
    start = 0; stop = 0; irq_clr = 0; cap_in = 0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
